// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: adds wide operands one nibble per clock through a shared four_bit_adder.
// Define SUB_MODE_EN to add the op_sub port (A-B in two's complement).
module four_bit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic [3:0] c
);
    logic cy;
    always_comb begin
        cy = cin;
        s  = '0;
        c  = '0;
        for (int i = 0; i < 4; i++) begin
            s[i] = a[i] ^ b[i] ^ cy;
            c[i] = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
            cy   = c[i];
        end
    end
endmodule

module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 cin,
`ifdef SUB_MODE_EN
    input  logic                 op_sub,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;

    logic [W-1:0]  a_q, b_q;
    logic [IW-1:0] idx;
    logic          carry, inv, cin0, last, accept;
    logic [3:0]    a_nib, b_nib, s, c;

    assign accept = state == IDLE && start;
    assign last   = idx == IW'(NIBBLES - 1);
    assign busy   = state != IDLE;
    assign done   = state == DONE;

`ifdef SUB_MODE_EN
    logic sub_q;
    always_ff @(posedge clk)
        if (!rst_n) sub_q <= 1'b0;
        else if (accept) sub_q <= op_sub;
    assign inv  = sub_q;
    assign cin0 = op_sub | cin;
`else
    assign inv  = 1'b0;
    assign cin0 = cin;
`endif

    assign a_nib = a_q[4*idx +: 4];
    assign b_nib = b_q[4*idx +: 4] ^ {4{inv}};

    four_bit_adder u_add (.a(a_nib), .b(b_nib), .cin(carry), .s(s), .c(c));

    always_ff @(posedge clk)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = IDLE;
        state_nx = state == IDLE ? (start ? RUN : IDLE) :
                   state == RUN  ? (last ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_q   <= op_a;
            b_q   <= op_b;
            carry <= cin0;
            idx   <= '0;
            sum   <= '0;
        end else if (state == RUN) begin
            sum[4*idx +: 4] <= s;
            carry           <= c[3];
            if (last) begin
                cout <= c[3];
                ovf  <= c[3] ^ c[2];
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: directed and random checks of nibble_serial_add_ctrl against an arithmetic model.
module tb_nibble_serial_add_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n, start, cin, op_sub;
    logic [W-1:0] op_a, op_b, sum;
    logic         busy, done, cout, ovf;
    int           checks = 0;
    int           fails  = 0;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef SUB_MODE_EN
        .op_sub(op_sub),
`endif
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci, input logic sub);
        logic [W-1:0] bb;
        logic [W:0]   r;
        logic         v;
        bb = sub ? ~b : b;
        r  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub | ci};
        v  = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
        return {v, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic sub, input string tag);
        logic [W+1:0] e;
        int           n;
        logic         busy_ok;
        e = model(a, b, ci, sub);
        op_a = a; op_b = b; cin = ci; op_sub = sub; start = 1'b1;
        tick();
        start = 1'b0;
        op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
        n = 0;
        busy_ok = 1'b1;
        while (!done && n < 20) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            n++;
        end
        check({tag, " latency"}, n, N);
        check({tag, " busy_run"}, {31'd0, busy_ok}, 1);
        check({tag, " busy_done"}, {31'd0, busy}, 1);
        check({tag, " sum"}, {16'd0, sum}, {16'd0, e[W-1:0]});
        check({tag, " cout"}, {31'd0, cout}, {31'd0, e[W]});
        check({tag, " ovf"}, {31'd0, ovf}, {31'd0, e[W+1]});
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " done_pulse"}, {31'd0, done}, 0);
        check({tag, " idle_busy"}, {31'd0, busy}, 0);
        check({tag, " sum_hold"}, {16'd0, sum}, {16'd0, e[W-1:0]});
    endtask

    initial begin
        int dones;
        logic busy_ok;
        rst_n = 1'b0; start = 1'b1; cin = 1'b0; op_sub = 1'b0;
        op_a = 16'hFFFF; op_b = 16'hFFFF;
        tick();
        tick();
        check("rst busy", {31'd0, busy}, 0);
        check("rst done", {31'd0, done}, 0);
        check("rst sum", {16'd0, sum}, 0);
        check("rst cout", {31'd0, cout}, 0);
        check("rst ovf", {31'd0, ovf}, 0);
        rst_n = 1'b1; start = 1'b0;
        tick();
        check("idle busy", {31'd0, busy}, 0);

        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, "basic");
        check("basic lit", {16'd0, sum}, 32'h2345);
        run_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, "ovf");
        check("ovf lit", {15'd0, cout, ovf, sum}, {15'd0, 1'b0, 1'b1, 16'h8000});
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "ripple");
        check("ripple lit", {15'd0, cout, ovf, sum}, {15'd0, 1'b1, 1'b0, 16'h0000});

        op_a = 16'h0001; op_b = 16'h0001; cin = 1'b0; start = 1'b1;
        tick();
        dones = 0;
        busy_ok = 1'b1;
        for (int j = 0; j <= N + 2; j++) begin
            if (j <= N && !busy) busy_ok = 1'b0;
            if (done) dones++;
            if (j == N) check("collide sum", {16'd0, sum}, 32'h0002);
            if (j == 2) begin
                start = 1'b1; op_a = 16'hFFFF; op_b = 16'hFFFF;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        check("collide dones", dones, 1);
        check("collide busy", {31'd0, busy_ok}, 1);
        check("collide idle", {31'd0, busy}, 0);
        check("collide hold", {16'd0, sum}, 32'h0002);

        op_a = 16'hAAAA; op_b = 16'h5555; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst busy", {31'd0, busy}, 0);
        check("midrst sum", {16'd0, sum}, 0);
        check("midrst done", {31'd0, done}, 0);
        check("midrst cout", {31'd0, cout}, 0);
        dones = 0;
        for (int j = 0; j < 6; j++) begin
            if (done || busy) dones++;
            tick();
        end
        check("midrst quiet", dones, 0);
        run_op(16'h000F, 16'h0001, 1'b0, 1'b0, "restart");
        check("restart lit", {16'd0, sum}, 32'h0010);

`ifdef SUB_MODE_EN
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, "sub1");
        check("sub1 lit", {15'd0, cout, 16'd0, sum}, {15'd0, 1'b0, 16'd0, 16'hFFFE});
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, "sub2");
        check("sub2 lit", {16'd0, ovf, sum[14:0]}, {16'd0, 1'b1, 15'h7FFF});
`endif

        for (int k = 0; k < 12; k++) begin
            logic sub;
`ifdef SUB_MODE_EN
            sub = 1'($urandom);
`else
            sub = 1'b0;
`endif
            run_op(W'($urandom), W'($urandom), 1'($urandom), sub, $sformatf("rnd%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
